// File: rtl/frame_sched_pkg.sv
// Shared types and helpers for the frame scheduler: FSM state encoding,
// buffer index type, ring size and small arithmetic helpers.
package frame_sched_pkg;

    localparam int NUM_BUFS = 3;

    typedef logic [1:0] buf_idx_t;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_FRAME = 3'd1,
        ST_LOAD       = 3'd2,
        ST_RUN        = 3'd3,
        ST_GAP        = 3'd4,
        ST_ERROR      = 3'd5
    } sched_state_e;

    // Indices of the three buffers sum to 3, so the one not named by a and b
    // is whatever remains.
    function automatic buf_idx_t free_buf(input buf_idx_t a, input buf_idx_t b);
        buf_idx_t r;
        r = 2'(NUM_BUFS) - a - b;
        return r;
    endfunction

    // 16-bit increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        logic [15:0] r;
        if (v == 16'hFFFF) begin
            r = v;
        end else begin
            r = v + 16'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/frame_scheduler_if.sv
// Uploader-side handshake between the frame scheduler (master) and the
// DMA uploader (slave).
interface frame_scheduler_if #(
    parameter int ADDR_W = 32
);
    logic              upl_enable;
    logic [ADDR_W-1:0] upl_base_address;
    logic [31:0]       upl_total_size;
    logic              upl_active;
    logic              upl_fifo_write;
    logic              upl_read_error;

    modport master (
        output upl_enable, upl_base_address, upl_total_size,
        input  upl_active, upl_fifo_write, upl_read_error
    );

    modport slave (
        input  upl_enable, upl_base_address, upl_total_size,
        output upl_active, upl_fifo_write, upl_read_error
    );
endinterface

// File: rtl/frame_buf_tracker.sv
// Triple-buffer rotation: tracks the displayed, pending and write buffers.
// A commit hands the writer's buffer over as pending; a load promotes the
// pending buffer to display. With FRAME_SCHED_STATS_EN defined, commits
// that overwrite an unconsumed pending buffer are counted as drops.
module frame_buf_tracker
    import frame_sched_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        buf_commit,
    output buf_idx_t    disp_idx,
    output buf_idx_t    wr_idx,
    output buf_idx_t    load_idx,
    output logic [15:0] frames_dropped
);
    buf_idx_t disp_r, pend_r, wr_r;
    logic     pend_valid_r;
    buf_idx_t disp_s, pend_s, wr_s;
    logic     pend_valid_s;

    // Next buffer assignment: load consumes the old pending first, then a
    // commit installs the writer's buffer as the new pending.
    always_comb begin
        disp_s       = disp_r;
        pend_s       = pend_r;
        pend_valid_s = pend_valid_r;
        wr_s         = wr_r;
        if (load && pend_valid_r) begin
            disp_s       = pend_r;
            pend_valid_s = 1'b0;
        end else begin
            disp_s       = disp_r;
        end
        if (buf_commit) begin
            pend_s       = wr_r;
            pend_valid_s = 1'b1;
            wr_s         = free_buf(wr_r, disp_s);
        end else begin
            wr_s         = wr_r;
        end
    end

    // Buffer index registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_r       <= 2'd0;
            pend_r       <= 2'd0;
            pend_valid_r <= 1'b0;
            wr_r         <= 2'd1;
        end else begin
            disp_r       <= disp_s;
            pend_r       <= pend_s;
            pend_valid_r <= pend_valid_s;
            wr_r         <= wr_s;
        end
    end

    assign disp_idx = disp_r;
    assign wr_idx   = wr_r;
    assign load_idx = pend_valid_r ? pend_r : disp_r;

`ifdef FRAME_SCHED_STATS_EN
    logic [15:0] dropped_r;

    // Count commits that overwrite a pending buffer nobody displayed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dropped_r <= 16'd0;
        end else if (buf_commit && pend_valid_r && !load) begin
            dropped_r <= sat_inc16(dropped_r);
        end else begin
            dropped_r <= dropped_r;
        end
    end

    assign frames_dropped = dropped_r;
`else
    assign frames_dropped = 16'd0;
`endif

endmodule

// File: rtl/frame_scheduler.sv
// Frame scheduler: on each vsync, points the uploader at the current display
// buffer, counts the words it pushes, and waits for it to go idle before the
// next frame. Optional statistics counters are built when the macro
// FRAME_SCHED_STATS_EN is defined.
module frame_scheduler
    import frame_sched_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ctrl_enable,
    input  logic [ADDR_W-1:0] base_address,
    input  logic [ADDR_W-1:0] buf_stride,
    input  logic [31:0]       frame_bytes,
    input  logic [CNT_W-1:0]  frame_words,
    input  logic              frame_start,
    input  logic              buf_commit,
    frame_scheduler_if.master upl,
    output logic [1:0]        wr_buf_idx,
    output logic [1:0]        disp_buf_idx,
    output logic              frame_done,
    output logic              error,
    output logic [15:0]       frames_shown,
    output logic [15:0]       frames_dropped,
    output logic [15:0]       underruns
);
    sched_state_e      state_r, state_s;
    logic [CNT_W-1:0]  word_cnt_r, word_cnt_s, cnt_inc_s;
    logic              upl_enable_r;
    logic [ADDR_W-1:0] upl_addr_r;
    logic [31:0]       upl_size_r;
    logic              frame_done_r, frame_done_s;
    logic              error_r, error_s;
    logic              load_s;
    buf_idx_t          load_idx_s;

    assign load_s = (state_r == ST_LOAD);

    frame_buf_tracker u_tracker (
        .clk            (clk),
        .rst            (rst),
        .load           (load_s),
        .buf_commit     (buf_commit),
        .disp_idx       (disp_buf_idx),
        .wr_idx         (wr_buf_idx),
        .load_idx       (load_idx_s),
        .frames_dropped (frames_dropped)
    );

    // Next-state, word count and pulse decode; a read error outranks the
    // final word, and dropping ctrl_enable overrides everything.
    always_comb begin
        state_s      = state_r;
        word_cnt_s   = word_cnt_r;
        frame_done_s = 1'b0;
        error_s      = error_r;
        cnt_inc_s    = word_cnt_r + CNT_W'(1);
        if (!ctrl_enable) begin
            state_s = ST_IDLE;
            error_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_s = ST_WAIT_FRAME;
                end
                ST_WAIT_FRAME: begin
                    if (frame_start) begin
                        state_s = ST_LOAD;
                    end else begin
                        state_s = ST_WAIT_FRAME;
                    end
                end
                ST_LOAD: begin
                    word_cnt_s = '0;
                    if (frame_words == '0) begin
                        state_s      = ST_WAIT_FRAME;
                        frame_done_s = 1'b1;
                    end else begin
                        state_s      = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (upl.upl_read_error) begin
                        state_s = ST_ERROR;
                        error_s = 1'b1;
                    end else if (upl.upl_fifo_write) begin
                        word_cnt_s = cnt_inc_s;
                        if (cnt_inc_s == frame_words) begin
                            state_s = ST_GAP;
                        end else begin
                            state_s = ST_RUN;
                        end
                    end else begin
                        state_s = ST_RUN;
                    end
                end
                ST_GAP: begin
                    if (upl.upl_read_error) begin
                        state_s = ST_ERROR;
                        error_s = 1'b1;
                    end else if (!upl.upl_active) begin
                        state_s      = ST_WAIT_FRAME;
                        frame_done_s = 1'b1;
                    end else begin
                        state_s = ST_GAP;
                    end
                end
                ST_ERROR: begin
                    state_s = ST_ERROR;
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end
    end

    // State, counter and registered uploader/status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            word_cnt_r   <= '0;
            upl_enable_r <= 1'b0;
            upl_addr_r   <= '0;
            upl_size_r   <= 32'd0;
            frame_done_r <= 1'b0;
            error_r      <= 1'b0;
        end else begin
            state_r      <= state_s;
            word_cnt_r   <= word_cnt_s;
            upl_enable_r <= (state_s == ST_RUN);
            frame_done_r <= frame_done_s;
            error_r      <= error_s;
            if (load_s) begin
                upl_addr_r <= base_address + (ADDR_W'(load_idx_s) * buf_stride);
                upl_size_r <= frame_bytes;
            end else begin
                upl_addr_r <= upl_addr_r;
                upl_size_r <= upl_size_r;
            end
        end
    end

    assign upl.upl_enable       = upl_enable_r;
    assign upl.upl_base_address = upl_addr_r;
    assign upl.upl_total_size   = upl_size_r;
    assign frame_done           = frame_done_r;
    assign error                = error_r;

`ifdef FRAME_SCHED_STATS_EN
    logic [15:0] shown_r, underrun_r;

    // Completed-frame and missed-vsync counters, saturating.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shown_r    <= 16'd0;
            underrun_r <= 16'd0;
        end else begin
            if (frame_done_s) begin
                shown_r <= sat_inc16(shown_r);
            end else begin
                shown_r <= shown_r;
            end
            if (frame_start && (state_r != ST_WAIT_FRAME)) begin
                underrun_r <= sat_inc16(underrun_r);
            end else begin
                underrun_r <= underrun_r;
            end
        end
    end

    assign frames_shown = shown_r;
    assign underruns    = underrun_r;
`else
    assign frames_shown = 16'd0;
    assign underruns    = 16'd0;
`endif

endmodule

// File: tb/tb_frame_scheduler.sv
// Directed bench for frame_scheduler. Counter expectations follow whether
// FRAME_SCHED_STATS_EN is defined for the build.
module tb_frame_scheduler;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ctrl_enable = 1'b0;
    logic [31:0] base_address = 32'h1000_0000;
    logic [31:0] buf_stride = 32'h0010_0000;
    logic [31:0] frame_bytes = 32'd16;
    logic [23:0] frame_words = 24'd4;
    logic        frame_start = 1'b0;
    logic        buf_commit = 1'b0;
    logic [1:0]  wr_buf_idx, disp_buf_idx;
    logic        frame_done, error;
    logic [15:0] frames_shown, frames_dropped, underruns;

    int checks = 0;
    int failures = 0;
    bit stats_on = 1'b0;

    frame_scheduler_if #(.ADDR_W(32)) upl_bus ();

    frame_scheduler #(.ADDR_W(32), .CNT_W(24)) dut (
        .clk            (clk),
        .rst            (rst),
        .ctrl_enable    (ctrl_enable),
        .base_address   (base_address),
        .buf_stride     (buf_stride),
        .frame_bytes    (frame_bytes),
        .frame_words    (frame_words),
        .frame_start    (frame_start),
        .buf_commit     (buf_commit),
        .upl            (upl_bus.master),
        .wr_buf_idx     (wr_buf_idx),
        .disp_buf_idx   (disp_buf_idx),
        .frame_done     (frame_done),
        .error          (error),
        .frames_shown   (frames_shown),
        .frames_dropped (frames_dropped),
        .underruns      (underruns)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        step();
    endtask

    // Four writes, uploader goes idle, then wait (bounded) for frame_done.
    task automatic finish_frame(input string name);
        bit seen;
        upl_bus.upl_active = 1'b1;
        for (int i = 0; i < 4; i++) begin
            upl_bus.upl_fifo_write = 1'b1;
            step();
        end
        upl_bus.upl_fifo_write = 1'b0;
        upl_bus.upl_active = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            step();
            if (frame_done === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b1) begin
            failures++;
            $display("FAIL %s_done: frame_done not seen within 8 cycles (got %0b, want 1)", name, seen);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if ({upl_bus.upl_enable, frame_done, error, disp_buf_idx, wr_buf_idx} !== 7'b000_0001) begin
            failures++;
            $display("FAIL reset_ctl: got %b want 0000001",
                     {upl_bus.upl_enable, frame_done, error, disp_buf_idx, wr_buf_idx});
        end
        checks++;
        if ({upl_bus.upl_base_address, upl_bus.upl_total_size} !== 64'd0) begin
            failures++;
            $display("FAIL reset_addr: got %h/%h want 0/0", upl_bus.upl_base_address, upl_bus.upl_total_size);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_single_frame();
        ctrl_enable = 1'b1;
        step();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        checks++;
        if (upl_bus.upl_enable !== 1'b0) begin
            failures++;
            $display("FAIL en_load: got %b want 0", upl_bus.upl_enable);
        end
        step();
        checks++;
        if (upl_bus.upl_enable !== 1'b1) begin
            failures++;
            $display("FAIL en_run: got %b want 1", upl_bus.upl_enable);
        end
        checks++;
        if (upl_bus.upl_base_address !== 32'h1000_0000 || upl_bus.upl_total_size !== 32'd16) begin
            failures++;
            $display("FAIL addr0: got %h/%0d want 10000000/16", upl_bus.upl_base_address, upl_bus.upl_total_size);
        end
        upl_bus.upl_active = 1'b1;
        for (int i = 0; i < 4; i++) begin
            upl_bus.upl_fifo_write = 1'b1;
            step();
        end
        upl_bus.upl_fifo_write = 1'b0;
        checks++;
        if (upl_bus.upl_enable !== 1'b0) begin
            failures++;
            $display("FAIL en_after_last: got %b want 0", upl_bus.upl_enable);
        end
        step();
        checks++;
        if (frame_done !== 1'b0) begin
            failures++;
            $display("FAIL done_gap: got %b want 0", frame_done);
        end
        upl_bus.upl_active = 1'b0;
        step();
        checks++;
        if (frame_done !== 1'b1) begin
            failures++;
            $display("FAIL done_pulse: got %b want 1", frame_done);
        end
        step();
        checks++;
        if (frame_done !== 1'b0 || frames_shown !== (stats_on ? 16'd1 : 16'd0)) begin
            failures++;
            $display("FAIL done_once: got done=%b shown=%0d want done=0 shown=%0d",
                     frame_done, frames_shown, stats_on ? 1 : 0);
        end
    endtask

    task automatic test_commit_swap();
        buf_commit = 1'b1;
        step();
        buf_commit = 1'b0;
        checks++;
        if (wr_buf_idx !== 2'd2 || disp_buf_idx !== 2'd0) begin
            failures++;
            $display("FAIL commit_idx: got wr=%0d disp=%0d want wr=2 disp=0", wr_buf_idx, disp_buf_idx);
        end
        start_frame();
        checks++;
        if (disp_buf_idx !== 2'd1 || wr_buf_idx !== 2'd2 || upl_bus.upl_base_address !== 32'h1010_0000) begin
            failures++;
            $display("FAIL swap: got disp=%0d wr=%0d addr=%h want 1/2/10100000",
                     disp_buf_idx, wr_buf_idx, upl_bus.upl_base_address);
        end
        finish_frame("swap");
    endtask

    task automatic test_drop();
        buf_commit = 1'b1;
        step();
        step();
        buf_commit = 1'b0;
        checks++;
        if (frames_dropped !== (stats_on ? 16'd1 : 16'd0) || wr_buf_idx !== 2'd2) begin
            failures++;
            $display("FAIL drop: got dropped=%0d wr=%0d want %0d/2", frames_dropped, wr_buf_idx, stats_on ? 1 : 0);
        end
        start_frame();
        checks++;
        if (disp_buf_idx !== 2'd0 || upl_bus.upl_base_address !== 32'h1000_0000) begin
            failures++;
            $display("FAIL drop_disp: got disp=%0d addr=%h want 0/10000000", disp_buf_idx, upl_bus.upl_base_address);
        end
        finish_frame("drop");
    endtask

    task automatic test_underrun();
        start_frame();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        checks++;
        if (underruns !== (stats_on ? 16'd1 : 16'd0) || upl_bus.upl_enable !== 1'b1) begin
            failures++;
            $display("FAIL underrun: got under=%0d en=%b want %0d/1", underruns, upl_bus.upl_enable, stats_on ? 1 : 0);
        end
        finish_frame("underrun");
        checks++;
        if (frames_shown !== (stats_on ? 16'd4 : 16'd0) || disp_buf_idx !== 2'd0) begin
            failures++;
            $display("FAIL shown4: got shown=%0d disp=%0d want %0d/0", frames_shown, disp_buf_idx, stats_on ? 4 : 0);
        end
    endtask

    // Zero-length frame whose LOAD coincides with a commit.
    task automatic test_zero_words_commit_load();
        buf_commit = 1'b1;
        step();
        buf_commit = 1'b0;
        checks++;
        if (wr_buf_idx !== 2'd1) begin
            failures++;
            $display("FAIL zw_commit: got wr=%0d want 1", wr_buf_idx);
        end
        frame_words = 24'd0;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        buf_commit = 1'b1;
        step();
        buf_commit = 1'b0;
        checks++;
        if (disp_buf_idx !== 2'd2 || wr_buf_idx !== 2'd0 || upl_bus.upl_base_address !== 32'h1020_0000) begin
            failures++;
            $display("FAIL coincide: got disp=%0d wr=%0d addr=%h want 2/0/10200000",
                     disp_buf_idx, wr_buf_idx, upl_bus.upl_base_address);
        end
        checks++;
        if (frame_done !== 1'b1 || upl_bus.upl_enable !== 1'b0 || frames_dropped !== (stats_on ? 16'd1 : 16'd0)) begin
            failures++;
            $display("FAIL zero_words: got done=%b en=%b dropped=%0d want 1/0/%0d",
                     frame_done, upl_bus.upl_enable, frames_dropped, stats_on ? 1 : 0);
        end
        step();
        checks++;
        if (frame_done !== 1'b0 || upl_bus.upl_enable !== 1'b0 || frames_shown !== (stats_on ? 16'd5 : 16'd0)) begin
            failures++;
            $display("FAIL zero_after: got done=%b en=%b shown=%0d want 0/0/%0d",
                     frame_done, upl_bus.upl_enable, frames_shown, stats_on ? 5 : 0);
        end
        frame_words = 24'd4;
    endtask

    task automatic test_read_error();
        start_frame();
        checks++;
        if (disp_buf_idx !== 2'd1 || upl_bus.upl_enable !== 1'b1) begin
            failures++;
            $display("FAIL err_pre: got disp=%0d en=%b want 1/1", disp_buf_idx, upl_bus.upl_enable);
        end
        upl_bus.upl_active = 1'b1;
        for (int i = 0; i < 3; i++) begin
            upl_bus.upl_fifo_write = 1'b1;
            step();
        end
        upl_bus.upl_read_error = 1'b1;
        step();
        upl_bus.upl_read_error = 1'b0;
        upl_bus.upl_fifo_write = 1'b0;
        upl_bus.upl_active = 1'b0;
        checks++;
        if (error !== 1'b1 || upl_bus.upl_enable !== 1'b0 || frame_done !== 1'b0) begin
            failures++;
            $display("FAIL err_set: got err=%b en=%b done=%b want 1/0/0", error, upl_bus.upl_enable, frame_done);
        end
        start_frame();
        step();
        checks++;
        if (error !== 1'b1 || upl_bus.upl_enable !== 1'b0 || frame_done !== 1'b0) begin
            failures++;
            $display("FAIL err_hold: got err=%b en=%b done=%b want 1/0/0", error, upl_bus.upl_enable, frame_done);
        end
        ctrl_enable = 1'b0;
        step();
        checks++;
        if (error !== 1'b0) begin
            failures++;
            $display("FAIL err_clear: got %b want 0", error);
        end
        ctrl_enable = 1'b1;
        step();
        start_frame();
        checks++;
        if (upl_bus.upl_enable !== 1'b1 || upl_bus.upl_base_address !== 32'h1010_0000) begin
            failures++;
            $display("FAIL err_recover: got en=%b addr=%h want 1/10100000", upl_bus.upl_enable, upl_bus.upl_base_address);
        end
        finish_frame("recover");
        checks++;
        if (underruns !== (stats_on ? 16'd2 : 16'd0)) begin
            failures++;
            $display("FAIL underrun2: got %0d want %0d", underruns, stats_on ? 2 : 0);
        end
    endtask

    task automatic test_reset_mid_run();
        start_frame();
        checks++;
        if (upl_bus.upl_enable !== 1'b1 || disp_buf_idx !== 2'd1 || wr_buf_idx !== 2'd0) begin
            failures++;
            $display("FAIL rst_pre: got en=%b disp=%0d wr=%0d want 1/1/0", upl_bus.upl_enable, disp_buf_idx, wr_buf_idx);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({upl_bus.upl_enable, frame_done, error, disp_buf_idx, wr_buf_idx} !== 7'b000_0001
            || upl_bus.upl_base_address !== 32'd0 || upl_bus.upl_total_size !== 32'd0) begin
            failures++;
            $display("FAIL rst_mid: got ctl=%b addr=%h size=%h want 0000001/0/0",
                     {upl_bus.upl_enable, frame_done, error, disp_buf_idx, wr_buf_idx},
                     upl_bus.upl_base_address, upl_bus.upl_total_size);
        end
        checks++;
        if (frames_shown !== 16'd0 || frames_dropped !== 16'd0 || underruns !== 16'd0) begin
            failures++;
            $display("FAIL rst_cnt: got %0d/%0d/%0d want 0/0/0", frames_shown, frames_dropped, underruns);
        end
        step();
        rst = 1'b0;
        step();
    endtask

    initial begin
`ifdef FRAME_SCHED_STATS_EN
        stats_on = 1'b1;
`endif
        upl_bus.upl_active = 1'b0;
        upl_bus.upl_fifo_write = 1'b0;
        upl_bus.upl_read_error = 1'b0;
        test_reset();
        test_single_frame();
        test_commit_swap();
        test_drop();
        test_underrun();
        test_zero_words_commit_load();
        test_read_error();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
